// File: rtl/vga_sync_gen_pkg.sv
// Shared constants and helpers for the VGA 640x480@60 timing generator.
//   - Default horizontal/vertical timing (pixels / lines).
//   - Axis counter width, RGB type and the bit order of {R,G,B} on the pins.
//   - Helpers for axis totals and the colour-bar test pattern.
package vga_sync_gen_pkg;

  localparam int unsigned CntW = 10;  // wide enough for 800 columns and 525 lines

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  // Bit positions of the colours inside a 3-bit {R,G,B} word.
  localparam int unsigned RgbR = 2;
  localparam int unsigned RgbG = 1;
  localparam int unsigned RgbB = 0;

  localparam int unsigned BarWidth = 80;  // test-pattern bar width in pixels

  typedef logic [2:0] rgb_t;

  function automatic int unsigned axis_total(int unsigned active, int unsigned fp,
                                             int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Colour of the vertical bar that column x falls into.
  function automatic rgb_t bar_rgb(logic [CntW-1:0] x);
    return rgb_t'(x / CntW'(BarWidth));
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel request channel between the VGA timing generator and the upstream pixel source.
//   pixel_req   : 1-clock pulse, pixel at pixel_x/pixel_y wanted
//   pixel_x/y   : requested column/row, held until the next request
//   frame_start : 1-clock pulse together with the request for (0,0)
//   pixel_data  : {R,G,B} for the last request, valid one clock after pixel_req
// Modports: master (timing generator), slave (pixel source).
interface vga_sync_gen_if;
  import vga_sync_gen_pkg::*;

  logic            pixel_req;
  logic [CntW-1:0] pixel_x;
  logic [CntW-1:0] pixel_y;
  logic            frame_start;
  rgb_t            pixel_data;

  modport master (
    output pixel_req,
    output pixel_x,
    output pixel_y,
    output frame_start,
    input  pixel_data
  );

  modport slave (
    input  pixel_req,
    input  pixel_x,
    input  pixel_y,
    input  frame_start,
    output pixel_data
  );

endinterface

// File: rtl/vga_sync_gen_sync_counter.sv
// One wrapping VGA axis counter (horizontal or vertical).
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance by one position
//   cnt        : current position
//   tc         : position is the last one of the axis (wraps to 0 on next en)
//   active     : position is inside the visible region
//   in_sync    : position is inside the sync pulse window
module vga_sync_gen_sync_counter
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned Active     = DefHActive,
  parameter int unsigned FrontPorch = DefHFp,
  parameter int unsigned SyncWidth  = DefHSync,
  parameter int unsigned BackPorch  = DefHBp
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic [CntW-1:0] cnt,
  output logic            tc,
  output logic            active,
  output logic            in_sync
);

  localparam int unsigned Total     = axis_total(Active, FrontPorch, SyncWidth, BackPorch);
  localparam int unsigned SyncStart = Active + FrontPorch;
  localparam int unsigned SyncEnd   = SyncStart + SyncWidth - 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc      = (cnt_q == CntW'(Total - 1));
  assign active  = (cnt_q < CntW'(Active));
  assign in_sync = (cnt_q >= CntW'(SyncStart)) && (cnt_q <= CntW'(SyncEnd));
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator and pixel output stage.
//   Clock      : system clock (50 MHz), pixel rate is Clock / CLK_DIV
//   Reset      : asynchronous, active-low
//   pix        : pixel request channel (master side), see vga_sync_gen_if
//   VGA_RED/GREEN/BLUE : colour pins, 000 during blanking
//   VGA_HS/VGA_VS      : sync pins, active low
// Pins for a position are registered on the tick that leaves it, so colour and
// both syncs lag the counters by exactly one pixel and stay mutually aligned.
// Optional feature: define VGA_TEST_PATTERN_EN to replace pixel_data by eight
// 80-pixel colour bars; requests are still issued.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp
) (
  input  logic           Clock,
  input  logic           Reset,
  vga_sync_gen_if.master pix,
  output logic           VGA_RED,
  output logic           VGA_GREEN,
  output logic           VGA_BLUE,
  output logic           VGA_HS,
  output logic           VGA_VS
);

  localparam int unsigned DivW = $clog2(CLK_DIV);

  logic [DivW-1:0] div_q, div_d;
  logic            tick, enter, active;
  logic [CntW-1:0] h_cnt, v_cnt;
  logic            h_tc, h_active, v_active, h_sync, v_sync;
  logic            unused_v_tc;
  logic            req_q, req_d, fs_q, fs_d;
  logic [CntW-1:0] x_q, x_d, y_q, y_d;
  rgb_t            pix_rgb, rgb_q, rgb_d;
  logic            hs_q, hs_d, vs_q, vs_d;

  // tick: last clock of a pixel. enter: first clock of a pixel, also true on
  // the first edge after reset release because div restarts at 0.
  assign tick   = (div_q == DivW'(CLK_DIV - 1));
  assign enter  = (div_q == '0);
  assign div_d  = tick ? '0 : div_q + 1'b1;
  assign active = h_active & v_active;

  vga_sync_gen_sync_counter #(
    .Active     (H_ACTIVE),
    .FrontPorch (H_FP),
    .SyncWidth  (H_SYNC),
    .BackPorch  (H_BP)
  ) u_h_cnt (
    .clk     (Clock),
    .rst_n   (Reset),
    .en      (tick),
    .cnt     (h_cnt),
    .tc      (h_tc),
    .active  (h_active),
    .in_sync (h_sync)
  );

  vga_sync_gen_sync_counter #(
    .Active     (V_ACTIVE),
    .FrontPorch (V_FP),
    .SyncWidth  (V_SYNC),
    .BackPorch  (V_BP)
  ) u_v_cnt (
    .clk     (Clock),
    .rst_n   (Reset),
    .en      (tick & h_tc),
    .cnt     (v_cnt),
    .tc      (unused_v_tc),
    .active  (v_active),
    .in_sync (v_sync)
  );

`ifdef VGA_TEST_PATTERN_EN
  rgb_t unused_pixel_data;
  assign unused_pixel_data = pix.pixel_data;
  assign pix_rgb           = bar_rgb(h_cnt);
`else
  rgb_t hold_q, hold_d;

  // With CLK_DIV == 2 the capture edge is also the tick leaving the pixel,
  // so the output stage must see the data being captured, not the old hold.
  assign hold_d  = req_q ? pix.pixel_data : hold_q;
  assign pix_rgb = hold_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  always_comb begin
    req_d = enter & active;
    fs_d  = enter & (h_cnt == '0) & (v_cnt == '0);
    x_d   = req_d ? h_cnt : x_q;
    y_d   = req_d ? v_cnt : y_q;
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (tick) begin
      rgb_d = active ? pix_rgb : '0;
      hs_d  = ~h_sync;
      vs_d  = ~v_sync;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      div_q <= '0;
      req_q <= 1'b0;
      fs_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      req_q <= req_d;
      fs_q  <= fs_d;
      x_q   <= x_d;
      y_q   <= y_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign pix.pixel_req   = req_q;
  assign pix.frame_start = fs_q;
  assign pix.pixel_x     = x_q;
  assign pix.pixel_y     = y_q;
  assign VGA_RED         = rgb_q[RgbR];
  assign VGA_GREEN       = rgb_q[RgbG];
  assign VGA_BLUE        = rgb_q[RgbB];
  assign VGA_HS          = hs_q;
  assign VGA_VS          = vs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen. Two instances share clock and reset:
// "full" with the default 640x480 timing and "small" with a tiny frame so that
// whole frames fit in a short run. A reference model derives every expected
// pin value from the number of clock edges since reset release.
module tb_vga_sync_gen;
  import vga_sync_gen_pkg::*;

  typedef struct {
    int d;
    int ha;
    int hfp;
    int hs;
    int hbp;
    int va;
    int vfp;
    int vs;
    int vbp;
  } cfg_t;

  localparam int unsigned SmDiv = 3;
  localparam int unsigned SmHA  = 8;
  localparam int unsigned SmHFP = 2;
  localparam int unsigned SmHS  = 3;
  localparam int unsigned SmHBP = 2;
  localparam int unsigned SmVA  = 4;
  localparam int unsigned SmVFP = 1;
  localparam int unsigned SmVS  = 2;
  localparam int unsigned SmVBP = 1;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  vga_sync_gen_if pix_full ();
  vga_sync_gen_if pix_small ();

  logic f_r, f_g, f_b, f_hs, f_vs;
  logic s_r, s_g, s_b, s_hs, s_vs;

  vga_sync_gen u_full (
    .Clock     (Clock),
    .Reset     (Reset),
    .pix       (pix_full),
    .VGA_RED   (f_r),
    .VGA_GREEN (f_g),
    .VGA_BLUE  (f_b),
    .VGA_HS    (f_hs),
    .VGA_VS    (f_vs)
  );

  vga_sync_gen #(
    .CLK_DIV  (SmDiv),
    .H_ACTIVE (SmHA),
    .H_FP     (SmHFP),
    .H_SYNC   (SmHS),
    .H_BP     (SmHBP),
    .V_ACTIVE (SmVA),
    .V_FP     (SmVFP),
    .V_SYNC   (SmVS),
    .V_BP     (SmVBP)
  ) u_small (
    .Clock     (Clock),
    .Reset     (Reset),
    .pix       (pix_small),
    .VGA_RED   (s_r),
    .VGA_GREEN (s_g),
    .VGA_BLUE  (s_b),
    .VGA_HS    (s_hs),
    .VGA_VS    (s_vs)
  );

  cfg_t  cfg [2];
  string name [2];
  int    n_checks = 0;
  int    n_errors = 0;
  int    edge_n   = 0;  // clock edges since reset release
  int    salt     = 0;
  bit    measuring = 1'b0;

  int exp_req [2], exp_fs [2], exp_x [2], exp_y [2], exp_rgb [2], exp_hs [2], exp_vs [2];
  int hs_fall1 [2], hs_fall2 [2], hs_rise1 [2], vs_fall1 [2], vs_rise1 [2];
  int fs1 [2], fs2 [2], line_reqs [2], frame_reqs [2];
  logic prev_hs [2], prev_vs [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_n, obs, exp_v);
    end
  endtask

  // Data the upstream source returns for pixel (x,y).
  function automatic int pix_value(input int x, input int y);
`ifdef VGA_TEST_PATTERN_EN
    return (x / 80) & 7;
`else
    return (x ^ (3 * y) ^ salt) & 7;
`endif
  endfunction

  // Expected channel and pin state right after edge edge_n.
  task automatic model_step(input int i);
    cfg_t c;
    int ht, vt, tot, p, px, py, k, q, qx, qy;
    c   = cfg[i];
    ht  = c.ha + c.hfp + c.hs + c.hbp;
    vt  = c.va + c.vfp + c.vs + c.vbp;
    tot = ht * vt;
    exp_req[i] = 0;
    exp_fs[i]  = 0;
    exp_rgb[i] = 0;
    exp_hs[i]  = 1;
    exp_vs[i]  = 1;
    if (edge_n == 0) begin
      exp_x[i] = 0;
      exp_y[i] = 0;
    end else begin
      if (edge_n % c.d == 1) begin
        p  = (edge_n / c.d) % tot;
        px = p % ht;
        py = p / ht;
        exp_fs[i] = (p == 0) ? 1 : 0;
        if (px < c.ha && py < c.va) begin
          exp_req[i] = 1;
          exp_x[i]   = px;
          exp_y[i]   = py;
        end
      end
      k = edge_n / c.d;
      if (k >= 1) begin
        q  = (k - 1) % tot;
        qx = q % ht;
        qy = q / ht;
        if (qx < c.ha && qy < c.va) exp_rgb[i] = pix_value(qx, qy);
        if (qx >= c.ha + c.hfp && qx < c.ha + c.hfp + c.hs) exp_hs[i] = 0;
        if (qy >= c.va + c.vfp && qy < c.va + c.vfp + c.vs) exp_vs[i] = 0;
      end
    end
  endtask

  task automatic check_inst(input int i, input logic req, input logic fs, input logic [9:0] x,
                            input logic [9:0] y, input logic [2:0] rgb, input logic hs,
                            input logic vs);
    check_eq({name[i], ".req"}, 32'(req), exp_req[i]);
    check_eq({name[i], ".frame_start"}, 32'(fs), exp_fs[i]);
    check_eq({name[i], ".x"}, 32'(x), exp_x[i]);
    check_eq({name[i], ".y"}, 32'(y), exp_y[i]);
    check_eq({name[i], ".rgb"}, 32'(rgb), exp_rgb[i]);
    check_eq({name[i], ".hs"}, 32'(hs), exp_hs[i]);
    check_eq({name[i], ".vs"}, 32'(vs), exp_vs[i]);
  endtask

  // Records sync edges, frame starts and request counts from the pins.
  task automatic measure(input int i, input logic hs, input logic vs, input logic fs,
                         input logic req);
    if (prev_hs[i] === 1'b1 && hs === 1'b0) begin
      if (hs_fall1[i] < 0) hs_fall1[i] = edge_n;
      else if (hs_fall2[i] < 0) hs_fall2[i] = edge_n;
    end
    if (prev_hs[i] === 1'b0 && hs === 1'b1 && hs_rise1[i] < 0) hs_rise1[i] = edge_n;
    if (prev_vs[i] === 1'b1 && vs === 1'b0 && vs_fall1[i] < 0) vs_fall1[i] = edge_n;
    if (prev_vs[i] === 1'b0 && vs === 1'b1 && vs_rise1[i] < 0) vs_rise1[i] = edge_n;
    prev_hs[i] = hs;
    prev_vs[i] = vs;
    if (fs === 1'b1) begin
      if (fs1[i] < 0) fs1[i] = edge_n;
      else if (fs2[i] < 0) fs2[i] = edge_n;
    end
    if (req === 1'b1) begin
      if (edge_n <= cfg[i].d * (cfg[i].ha + cfg[i].hfp + cfg[i].hs + cfg[i].hbp))
        line_reqs[i]++;
      if (fs1[i] >= 0 && fs2[i] < 0) frame_reqs[i]++;
    end
  endtask

  task automatic sample_all();
    model_step(0);
    model_step(1);
    check_inst(0, pix_full.pixel_req, pix_full.frame_start, pix_full.pixel_x,
               pix_full.pixel_y, {f_r, f_g, f_b}, f_hs, f_vs);
    check_inst(1, pix_small.pixel_req, pix_small.frame_start, pix_small.pixel_x,
               pix_small.pixel_y, {s_r, s_g, s_b}, s_hs, s_vs);
  endtask

  task automatic run_cycles(input int cnt);
    for (int c = 0; c < cnt; c++) begin
      @(posedge Clock);
      #1;
      if (Reset) edge_n++;
      sample_all();
      if (measuring) begin
        measure(0, f_hs, f_vs, pix_full.frame_start, pix_full.pixel_req);
        measure(1, s_hs, s_vs, pix_small.frame_start, pix_small.pixel_req);
      end
      // Return data for a pending request; anything else is noise that must be ignored.
      pix_full.pixel_data  = (exp_req[0] != 0) ? 3'(pix_value(exp_x[0], exp_y[0]))
                                               : 3'($urandom_range(0, 7));
      pix_small.pixel_data = (exp_req[1] != 0) ? 3'(pix_value(exp_x[1], exp_y[1]))
                                               : 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    int ht, vt;
    cfg[0]  = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg[1]  = '{SmDiv, SmHA, SmHFP, SmHS, SmHBP, SmVA, SmVFP, SmVS, SmVBP};
    name[0] = "full";
    name[1] = "small";
    salt    = $urandom_range(0, 7);
    for (int i = 0; i < 2; i++) begin
      hs_fall1[i] = -1; hs_fall2[i] = -1; hs_rise1[i] = -1;
      vs_fall1[i] = -1; vs_rise1[i] = -1;
      fs1[i] = -1; fs2[i] = -1;
      line_reqs[i] = 0; frame_reqs[i] = 0;
      prev_hs[i] = 1'b1; prev_vs[i] = 1'b1;
    end
    pix_full.pixel_data  = 3'd0;
    pix_small.pixel_data = 3'd0;

    // Held in reset for 10 clocks, then released between edges.
    run_cycles(10);
    #2 Reset = 1'b1;
    measuring = 1'b1;
    run_cycles(3000);
    measuring = 1'b0;

    for (int i = 0; i < 2; i++) begin
      ht = cfg[i].ha + cfg[i].hfp + cfg[i].hs + cfg[i].hbp;
      check_eq({name[i], ".hs_first_fall"}, hs_fall1[i], cfg[i].d * (cfg[i].ha + cfg[i].hfp + 1));
      check_eq({name[i], ".hs_period"}, hs_fall2[i] - hs_fall1[i], cfg[i].d * ht);
      check_eq({name[i], ".hs_low"}, hs_rise1[i] - hs_fall1[i], cfg[i].d * cfg[i].hs);
      check_eq({name[i], ".line_reqs"}, line_reqs[i], cfg[i].ha);
      check_eq({name[i], ".fs_first"}, fs1[i], 1);
    end
    ht = cfg[1].ha + cfg[1].hfp + cfg[1].hs + cfg[1].hbp;
    vt = cfg[1].va + cfg[1].vfp + cfg[1].vs + cfg[1].vbp;
    check_eq("small.vs_first_fall", vs_fall1[1], cfg[1].d * (ht * (cfg[1].va + cfg[1].vfp) + 1));
    check_eq("small.vs_low", vs_rise1[1] - vs_fall1[1], cfg[1].d * ht * cfg[1].vs);
    check_eq("small.frame_period", fs2[1] - fs1[1], cfg[1].d * ht * vt);
    check_eq("small.frame_reqs", frame_reqs[1], cfg[1].ha * cfg[1].va);

    // Asynchronous reset at a random point mid-line; outputs must clear before the next edge.
    run_cycles($urandom_range(1, 600));
    #2 Reset = 1'b0;
    edge_n = 0;
    #1 sample_all();
    run_cycles(5);
    #2 Reset = 1'b1;
    run_cycles(1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
